// File: rtl/tx_serial_8n1.sv
// tx_serial_8n1: 8N1 asynchronous serial transmitter (LSB first, idle-high line).
//
// Parameters:
//   M - clock cycles per bit (>= 2), N - baud counter width (2**N >= M)
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   partida      in   start request, sampled only when idle
//   dados_ascii  in   byte to send, captured when partida is accepted
//   saida_serial out  registered serial line
//   ocupado      out  high while the frame is on the line
//   pronto       out  one-cycle pulse after the stop bit
//   db_estado    out  state code for debug (IDLE=0, TX=1, DONE=F)
module tx_serial_8n1 #(
    parameter int unsigned M = 434,
    parameter int unsigned N = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados_ascii,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int unsigned FRAME_W = 10;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned ST_W    = 4;

    localparam logic [ST_W-1:0] IDLE = 4'h0;
    localparam logic [ST_W-1:0] TX   = 4'h1;
    localparam logic [ST_W-1:0] DONE = 4'hF;

    localparam logic [N-1:0]     BAUD_LAST = N'(M - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);

    logic [ST_W-1:0]    r_state;
    logic [FRAME_W-1:0] r_frame;
    logic [N-1:0]       r_baud;
    logic [BIT_W-1:0]   r_bit;
    logic               r_saida;
    logic               r_ocupado;
    logic               r_pronto;

    logic [ST_W-1:0]    w_state_next;
    logic [FRAME_W-1:0] w_frame_next;
    logic [N-1:0]       w_baud_next;
    logic [BIT_W-1:0]   w_bit_next;
    logic               w_saida_next;
    logic               w_ocupado_next;
    logic               w_pronto_next;

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_frame   <= '1;
            r_baud    <= '0;
            r_bit     <= '0;
            r_saida   <= 1'b1;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_frame   <= w_frame_next;
            r_baud    <= w_baud_next;
            r_bit     <= w_bit_next;
            r_saida   <= w_saida_next;
            r_ocupado <= w_ocupado_next;
            r_pronto  <= w_pronto_next;
        end
    end

    // Next-state and next-output logic; the line register is loaded with the
    // bit that will be on the frame LSB next cycle, so it tracks the frame
    // without an extra cycle of delay.
    always_comb begin
        w_state_next   = r_state;
        w_frame_next   = r_frame;
        w_baud_next    = r_baud;
        w_bit_next     = r_bit;
        w_saida_next   = 1'b1;
        w_ocupado_next = 1'b0;
        w_pronto_next  = 1'b0;

        case (r_state)
            IDLE: begin
                if (partida) begin
                    w_state_next   = TX;
                    w_frame_next   = {1'b1, dados_ascii, 1'b0};
                    w_baud_next    = '0;
                    w_bit_next     = '0;
                    w_saida_next   = 1'b0;
                    w_ocupado_next = 1'b1;
                end
            end

            TX: begin
                w_ocupado_next = 1'b1;
                w_saida_next   = r_frame[0];
                if (r_baud == BAUD_LAST) begin
                    w_baud_next = '0;
                    if (r_bit == BIT_LAST) begin
                        // Stop bit finished: leave the line idle and flag completion
                        w_state_next   = DONE;
                        w_saida_next   = 1'b1;
                        w_ocupado_next = 1'b0;
                        w_pronto_next  = 1'b1;
                    end else begin
                        w_frame_next = {1'b1, r_frame[FRAME_W-1:1]};
                        w_bit_next   = r_bit + BIT_W'(1);
                        w_saida_next = r_frame[1];
                    end
                end else begin
                    w_baud_next = r_baud + N'(1);
                end
            end

            DONE: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign saida_serial = r_saida;
    assign ocupado      = r_ocupado;
    assign pronto       = r_pronto;
    assign db_estado    = r_state;

endmodule

// File: tb/tb_tx_serial_8n1.sv
// Testbench for tx_serial_8n1: two instances (M=4 and M=434) checked every
// cycle against a frame-timing model plus literal spot checks.
module tb_tx_serial_8n1;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       par [2];
    logic [7:0] dat [2];
    logic       ser [2];
    logic       ocu [2];
    logic       pro [2];
    logic [3:0] dbe [2];

    tx_serial_8n1 #(.M(4), .N(3)) dut4 (
        .clock(clk), .reset(rst[0]), .partida(par[0]), .dados_ascii(dat[0]),
        .saida_serial(ser[0]), .ocupado(ocu[0]), .pronto(pro[0]), .db_estado(dbe[0])
    );

    tx_serial_8n1 #(.M(434), .N(9)) dut434 (
        .clock(clk), .reset(rst[1]), .partida(par[1]), .dados_ascii(dat[1]),
        .saida_serial(ser[1]), .ocupado(ocu[1]), .pronto(pro[1]), .db_estado(dbe[1])
    );

    // Model: a frame is described by its acceptance cycle and byte only
    int         cyc = 0;
    int         mm [2] = '{4, 434};
    bit         act [2];
    int         t0 [2];
    logic [7:0] mb [2];
    bit         chk_en [2];
    int         n_chk = 0;
    int         n_fail = 0;
    int         c0 = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                act[i]    = 1'b0;
                chk_en[i] = 1'b1;
            end else if (par[i] && (!act[i] || (cyc - t0[i]) >= 10*mm[i] + 2)) begin
                act[i] = 1'b1;
                t0[i]  = cyc;
                mb[i]  = dat[i];
            end
        end
        cyc++;
    end

    task automatic model_out(input int i, input int c, output logic s, output logic o,
                             output logic p, output logic [3:0] st);
        int         rel;
        logic [9:0] fr;
        rel = c - t0[i];
        fr  = {1'b1, mb[i], 1'b0};
        s = 1'b1; o = 1'b0; p = 1'b0; st = 4'h0;
        if (act[i]) begin
            if (rel >= 1 && rel <= 10*mm[i]) begin
                s  = fr[(rel-1)/mm[i]];
                o  = 1'b1;
                st = 4'h1;
            end else if (rel == 10*mm[i] + 1) begin
                p  = 1'b1;
                st = 4'hF;
            end
        end
    endtask

    task automatic check(input string nm, input int i, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, i, cyc, got, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic       s, o, p;
        logic [3:0] st;
        for (int i = 0; i < 2; i++) begin
            if (chk_en[i]) begin
                model_out(i, cyc, s, o, p, st);
                check("saida_serial", i, {3'b0, ser[i]}, {3'b0, s});
                check("ocupado", i, {3'b0, ocu[i]}, {3'b0, o});
                check("pronto", i, {3'b0, pro[i]}, {3'b0, p});
                check("db_estado", i, dbe[i], st);
            end
        end
    end

    task automatic to_rel(input int k);
        while (cyc < c0 + k) @(negedge clk);
    endtask

    task automatic lit(input string nm, input int i, input logic s, input logic o, input logic p);
        check({nm, "_saida"}, i, {3'b0, ser[i]}, {3'b0, s});
        check({nm, "_ocupado"}, i, {3'b0, ocu[i]}, {3'b0, o});
        check({nm, "_pronto"}, i, {3'b0, pro[i]}, {3'b0, p});
    endtask

    task automatic start(input int i, input logic [7:0] b);
        c0     = cyc;
        par[i] = 1'b1;
        dat[i] = b;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; par[i] = 1'b0; dat[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Reset then idle
        c0 = cyc;
        to_rel(50);
        lit("idle", 0, 1'b1, 1'b0, 1'b0);
        check("idle_state", 0, dbe[0], 4'h0);

        // Single byte 0x55
        start(0, 8'h55);
        to_rel(1);  par[0] = 1'b0; dat[0] = 8'($urandom);
        lit("x55_start", 0, 1'b0, 1'b1, 1'b0);
        to_rel(5);  lit("x55_b0", 0, 1'b1, 1'b1, 1'b0);
        to_rel(9);  lit("x55_b1", 0, 1'b0, 1'b1, 1'b0);
        to_rel(33); lit("x55_b7", 0, 1'b0, 1'b1, 1'b0);
        to_rel(37); lit("x55_stop", 0, 1'b1, 1'b1, 1'b0);
        to_rel(41); lit("x55_done", 0, 1'b1, 1'b0, 1'b1);
        check("x55_done_state", 0, dbe[0], 4'hF);
        to_rel(42); lit("x55_idle", 0, 1'b1, 1'b0, 1'b0);

        // Data changes mid-frame
        start(0, 8'hA3);
        to_rel(1);  par[0] = 1'b0;
        to_rel(10); dat[0] = 8'hFF;
        to_rel(13); lit("xa3_b2", 0, 1'b0, 1'b1, 1'b0);
        to_rel(25); lit("xa3_b5", 0, 1'b1, 1'b1, 1'b0);
        to_rel(29); lit("xa3_b6", 0, 1'b0, 1'b1, 1'b0);
        to_rel(33); lit("xa3_b7", 0, 1'b1, 1'b1, 1'b0);
        to_rel(45);

        // Ignored starts during TX and DONE
        start(0, 8'h3C);
        to_rel(1);  par[0] = 1'b0;
        to_rel(5);  par[0] = 1'b1; dat[0] = 8'h00;
        to_rel(6);  par[0] = 1'b0;
        to_rel(9);  lit("ign_b1", 0, 1'b0, 1'b1, 1'b0);
        to_rel(17); lit("ign_b3", 0, 1'b1, 1'b1, 1'b0);
        to_rel(41); par[0] = 1'b1;
        lit("ign_done", 0, 1'b1, 1'b0, 1'b1);
        to_rel(42); par[0] = 1'b0;
        to_rel(43); lit("ign_none", 0, 1'b1, 1'b0, 1'b0);
        to_rel(50); lit("ign_idle", 0, 1'b1, 1'b0, 1'b0);

        // Back-to-back with partida held high
        start(0, 8'h00);
        to_rel(1);  lit("b2b_s1", 0, 1'b0, 1'b1, 1'b0);
        to_rel(41); lit("b2b_p1", 0, 1'b1, 1'b0, 1'b1);
        to_rel(42); lit("b2b_gap", 0, 1'b1, 1'b0, 1'b0);
        to_rel(43); lit("b2b_s2", 0, 1'b0, 1'b1, 1'b0);
        to_rel(83); lit("b2b_p2", 0, 1'b1, 1'b0, 1'b1);
        to_rel(85); lit("b2b_s3", 0, 1'b0, 1'b1, 1'b0);
        par[0] = 1'b0;
        to_rel(130);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            par[0] = ($urandom_range(0, 7) == 0);
            dat[0] = 8'($urandom);
            rst[0] = ($urandom_range(0, 199) == 0);
        end
        rst[0] = 1'b0; par[0] = 1'b0;

        // Mid-frame reset at M=434, then a full frame
        start(1, 8'h41);
        to_rel(1);    par[1] = 1'b0;
        lit("mr_start", 1, 1'b0, 1'b1, 1'b0);
        to_rel(2000); rst[1] = 1'b1;
        to_rel(2001); rst[1] = 1'b0;
        lit("mr_reset", 1, 1'b1, 1'b0, 1'b0);
        check("mr_state", 1, dbe[1], 4'h0);
        to_rel(2010); lit("mr_quiet", 1, 1'b1, 1'b0, 1'b0);
        start(1, 8'h41);
        to_rel(1);    par[1] = 1'b0;
        to_rel(435);  lit("x41_b0", 1, 1'b1, 1'b1, 1'b0);
        to_rel(869);  lit("x41_b1", 1, 1'b0, 1'b1, 1'b0);
        to_rel(3039); lit("x41_b6", 1, 1'b1, 1'b1, 1'b0);
        to_rel(3473); lit("x41_b7", 1, 1'b0, 1'b1, 1'b0);
        to_rel(3907); lit("x41_stop", 1, 1'b1, 1'b1, 1'b0);
        to_rel(4341); lit("x41_done", 1, 1'b1, 1'b0, 1'b1);
        to_rel(4342); lit("x41_idle", 1, 1'b1, 1'b0, 1'b0);
        to_rel(4350);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_serial_8n1.md
# tx_serial_8N1

Asynchronous serial transmitter for 8N1 framing: 8 data bits, no parity, 1 stop bit, LSB first. It is the transmit-side counterpart of the serial receiver and uses the same baud divisor convention (clock cycles per bit). A host pulses `partida` with a byte on `dados_ascii`. The block serialises one idle-high frame onto `saida_serial` and signals `pronto` for one cycle when the stop bit has completed.

## Interface
- `M`, default 434: clock cycles per bit (50 MHz / 115200). 5208 gives 9600 baud. Legal range M ≥ 2.
- `N`, default 9: baud counter width. Must satisfy 2^N ≥ M.

- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `partida` in 1: start request; sampled only in state IDLE.
- `dados_ascii` in 8: byte to send; captured in the cycle `partida` is accepted.
- `saida_serial` out 1: serial line, registered, idle high.
- `ocupado` out 1: high while a frame is in progress (state TX).
- `pronto` out 1: one-cycle pulse after the stop bit ends.
- `db_estado` out 4: state code for debug display. IDLE=0, TX=1, DONE=F.

## Operation
- FSM states: IDLE, TX, DONE.
  - IDLE with `partida`=1 → TX.
  - TX after the 10th bit period → DONE.
  - DONE → IDLE unconditionally.
- Frame register (10 bits): on acceptance, load {1, dados_ascii[7:0], 0}, with bit 0 as the start bit. The baud counter and bit counter (0..9) clear to 0 at the same time.
- In TX:
  - The baud counter counts 0..M-1.
  - At count M-1, the frame register shifts right by one, filling with 1. The bit counter increments and the baud counter wraps to 0.
  - When count M-1 coincides with bit counter = 9, the FSM goes to DONE instead of shifting.
- `saida_serial` is a registered copy of frame register bit 0 while in TX, and 1 in IDLE and DONE.
- `dados_ascii` is don't-care after acceptance. Changing it mid-frame has no effect.
- `partida` in TX or DONE is ignored; there is no queuing. `partida` held high continuously restarts a new frame on each return to IDLE.
- `reset` (synchronous, in any state, including mid-frame) sets the following on the next edge:
  - state = IDLE
  - counters = 0
  - frame register = all 1s
  - `saida_serial`=1, `ocupado`=0, `pronto`=0
  
  A truncated frame is not completed.

## Timing
- Reset values: `saida_serial`=1, `ocupado`=0, `pronto`=0, `db_estado`=0.
- Let cycle 0 be the cycle in which `partida`=1 is sampled in IDLE.
  - Cycles 1..M: `saida_serial`=0 (start bit).
  - Cycles kM+1..(k+1)M: data bit k-1, for k=1..8.
  - Cycles 9M+1..10M: `saida_serial`=1 (stop bit).
  - `ocupado`=1 exactly on cycles 1..10M.
  - Cycle 10M+1: DONE. `pronto`=1, `saida_serial`=1, `ocupado`=0.
  - Cycle 10M+2: IDLE. The earliest next accepted `partida` gives the next start bit from cycle 10M+3.
- Every bit lasts exactly M cycles, with no drift across the frame.
- Latency from accepted `partida` to the falling edge of the start bit is 1 cycle.

## Test plan
- Reset then idle, M=4: hold `reset`=1 for 3 cycles, release, run 50 cycles → `saida_serial`=1, `ocupado`=0, `pronto`=0, `db_estado`=0 throughout.
- Single byte, M=4, `dados_ascii`=8'h55, `partida` pulse at cycle 0 → cycles 1–4 low, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high on 37–40, `pronto`=1 only on cycle 41.
- Data change mid-frame: send 8'hA3, then force `dados_ascii`=8'hFF at cycle 10 → line still carries 1,1,0,0,0,1,0,1 (LSB first).
- Ignored start: `partida` pulses at cycles 5 and 41 during a frame with M=4 → a single frame only, and `ocupado` drops after cycle 40.
- Back-to-back: `partida` held high with M=4 and 8'h00 → start bits begin on cycles 1, 43, 85. There are 2 idle/done cycles between frames, and `pronto` pulses on cycles 41 and 83.
- Mid-frame reset: M=434, send 8'h41, assert `reset` at cycle 2000 for 1 cycle → `saida_serial`=1 and `ocupado`=0 from cycle 2001, with no `pronto`. A subsequent `partida` produces a full, correct frame for 8'h41.
